// File: rtl/code_conv_pkg.sv
// Shared types and constants for the bit-serial binary/Gray converter.
package code_conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MSB  = 3'd2,
    ST_BIT  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  // Bit-index counter width; a 1-bit operand still gets a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/code_conv_cnt.sv
// Parametrised down-counter with load and zero flag; never wraps below zero.
module code_conv_cnt #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/code_conv_seq.sv
// Bit-serial binary<->Gray converter, MSB first, with busy/done handshake.
// Optional registered parity of the result when CODE_CONV_PARITY_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start; dout holds last result
// LOAD    | operand captured, dout cleared
// MSB     | copy top bit
// BIT     | one lower bit per clock, index = cnt
// DONE    | result valid; wait for start to drop
module code_conv_seq
  import code_conv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_parity
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = (WIDTH > 1) ? CNT_W'(WIDTH - 2) : '0;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_mode;
  logic [WIDTH-1:0] r_in;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_dout_next;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_zero;
  logic             w_cnt_load;
  logic             w_cnt_dec;

  // Operand is captured on the edge that accepts start, so anything
  // driven on din/mode while busy is never seen.
  assign w_cnt_load = (r_state == ST_IDLE) && i_start;
  assign w_cnt_dec  = (r_state == ST_BIT);

  code_conv_cnt #(.W(CNT_W)) u_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_cnt_load),
    .i_dec      (w_cnt_dec),
    .i_load_val (CNT_INIT),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_dout_next = r_dout;
    case (r_state)
      ST_IDLE: if (i_start) w_dout_next = '0;
      ST_MSB:  w_dout_next[WIDTH-1] = r_in[WIDTH-1];
      ST_BIT: begin
        for (int k = 0; k < WIDTH - 1; k++) begin
          if (k == int'(w_cnt)) begin
            case (r_mode)
              MODE_B2G: w_dout_next[k] = r_in[k+1] ^ r_in[k];
              MODE_G2B: w_dout_next[k] = r_dout[k+1] ^ r_in[k];
              default:  w_dout_next[k] = r_dout[k];
            endcase
          end
        end
      end
      default: w_dout_next = r_dout;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mode  <= 1'b0;
      r_in    <= '0;
      r_dout  <= '0;
    end else begin
      r_dout <= w_dout_next;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
            r_in    <= i_din;
            r_mode  <= i_mode;
          end
        end
        ST_LOAD: r_state <= ST_MSB;
        ST_MSB: begin
          if (WIDTH == 1) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_BIT;
          end
        end
        ST_BIT: begin
          if (w_cnt_zero) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!i_start) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_dout = r_dout;

`ifdef CODE_CONV_PARITY_EN
  logic r_parity;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_parity <= 1'b0;
    else         r_parity <= ^w_dout_next;
  end

  assign o_parity = r_parity;
`else
  assign o_parity = 1'b0;
`endif

endmodule

// File: tb/tb_code_conv_seq.sv
// Directed bench for code_conv_seq: WIDTH=8 main instance plus WIDTH=1 and WIDTH=3.
module tb_code_conv_seq;

`ifdef CODE_CONV_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] din = 8'h00;
  logic       busy, done, parity;
  logic [7:0] dout;

  logic       start1 = 1'b0, mode1 = 1'b0;
  logic [0:0] din1 = 1'b0;
  logic       busy1, done1, parity1;
  logic [0:0] dout1;

  logic       start3 = 1'b0, mode3 = 1'b0;
  logic [2:0] din3 = 3'b000;
  logic       busy3, done3, parity3;
  logic [2:0] dout3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  code_conv_seq #(.WIDTH(8)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_mode(mode), .i_din(din),
    .o_busy(busy), .o_done(done), .o_dout(dout), .o_parity(parity)
  );

  code_conv_seq #(.WIDTH(1)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_start(start1), .i_mode(mode1), .i_din(din1),
    .o_busy(busy1), .o_done(done1), .o_dout(dout1), .o_parity(parity1)
  );

  code_conv_seq #(.WIDTH(3)) dut3 (
    .i_clk(clk), .i_reset(reset), .i_start(start3), .i_mode(mode3), .i_din(din3),
    .o_busy(busy3), .o_done(done3), .o_dout(dout3), .o_parity(parity3)
  );

  task automatic run_conv(input string name, input logic m, input logic [7:0] d,
                          input logic [7:0] exp_dout, input logic exp_par, input bit toggle);
    int lat;
    int busy_n;
    logic exp_p;
    exp_p = PAR_EN & exp_par;
    @(negedge clk);
    mode = m; din = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0; busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      if (toggle) begin din = ~din; mode = ~mode; end
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 9) begin errors++; $display("FAIL %s latency got %0d want 9", name, lat); end
    checks++; if (busy_n !== 9) begin errors++; $display("FAIL %s busy_cycles got %0d want 9", name, busy_n); end
    checks++; if (dout !== exp_dout) begin errors++; $display("FAIL %s dout got %h want %h", name, dout, exp_dout); end
    checks++; if (parity !== exp_p) begin errors++; $display("FAIL %s parity got %b want %b", name, parity, exp_p); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_in_done got %b want 0", name, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_after_drop got %b want 0", name, done); end
    checks++; if (dout !== exp_dout) begin errors++; $display("FAIL %s dout_hold got %h want %h", name, dout, exp_dout); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b want 0", done); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset dout got %h want 00", dout); end
    checks++; if (parity !== 1'b0) begin errors++; $display("FAIL reset parity got %b want 0", parity); end
    checks++; if ({done1, dout1, done3, dout3} !== 5'b0) begin errors++; $display("FAIL reset small got %b want 0", {done1, dout1, done3, dout3}); end
    // start and reset on the same edge: reset must win
    start = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_vs_start busy got %b want 0", busy); end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_b2g_g2b();
    run_conv("b2g_B6", 1'b0, 8'hB6, 8'hED, 1'b0, 1'b0);
    run_conv("g2b_ED", 1'b1, 8'hED, 8'hB6, 1'b1, 1'b0);
  endtask

  task automatic test_edges();
    run_conv("b2g_FF", 1'b0, 8'hFF, 8'h80, 1'b1, 1'b0);
    run_conv("b2g_00", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    run_conv("g2b_80", 1'b1, 8'h80, 8'hFF, 1'b0, 1'b0);
  endtask

  task automatic test_toggle_busy();
    run_conv("toggle_B6", 1'b0, 8'hB6, 8'hED, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    mode = 1'b0; din = 8'hB6; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0;
    while (lat < 4) begin @(negedge clk); lat++; end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_mid done got %b want 0", done); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_mid dout got %h want 00", dout); end
    checks++; if (parity !== 1'b0) begin errors++; $display("FAIL reset_mid parity got %b want 0", parity); end
    reset = 1'b0;
    run_conv("after_reset_B6", 1'b0, 8'hB6, 8'hED, 1'b0, 1'b0);
  endtask

  task automatic test_hold_start();
    int lat;
    @(negedge clk);
    mode = 1'b0; din = 8'h3C; start = 1'b1;
    lat = 0;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL hold reach_done got %b want 1", done); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || dout !== 8'h22) begin
        errors++;
        $display("FAIL hold cycle %0d got done=%b busy=%b dout=%h want done=1 busy=0 dout=22", i, done, busy, dout);
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hold drop got done=%b busy=%b want 0 0", done, busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || dout !== 8'h22) begin errors++; $display("FAIL hold idle got busy=%b dout=%h want 0 22", busy, dout); end
  endtask

  task automatic test_width1();
    int lat;
    @(negedge clk);
    din1 = 1'b1; mode1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; lat = 0;
    while (!done1 && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat !== 2) begin errors++; $display("FAIL w1 latency got %0d want 2", lat); end
    checks++; if (dout1 !== 1'b1) begin errors++; $display("FAIL w1 dout got %b want 1", dout1); end
    checks++; if (parity1 !== PAR_EN) begin errors++; $display("FAIL w1 parity got %b want %b", parity1, PAR_EN); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL w1 busy got %b want 0", busy1); end
  endtask

  task automatic test_width3();
    int lat;
    @(negedge clk);
    din3 = 3'b110; mode3 = 1'b1; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0; lat = 0;
    while (!done3 && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat !== 4) begin errors++; $display("FAIL w3 latency got %0d want 4", lat); end
    checks++; if (dout3 !== 3'b100) begin errors++; $display("FAIL w3 dout got %b want 100", dout3); end
    checks++; if (parity3 !== PAR_EN) begin errors++; $display("FAIL w3 parity got %b want %b", parity3, PAR_EN); end
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL w3 busy got %b want 0", busy3); end
  endtask

  initial begin
    test_reset();
    test_b2g_g2b();
    test_edges();
    test_toggle_busy();
    test_reset_mid();
    test_hold_start();
    test_width1();
    test_width3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
